// File: rtl/instruction_fetch.sv
// Fetch-side PC owner: issues reads to a 1-cycle synchronous imem, buffers returned
// instructions tagged with their PC, and hands them to decode over valid/ready.
module instruction_fetch #(
    parameter int              PC_W      = 32,
    parameter int              INSTR_W   = 9,
    parameter int              PC_STEP   = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    output logic               done
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    entry_t            mem_q [BUF_DEPTH];
    entry_t            mem_d [BUF_DEPTH];

    logic              pop, push, room;
    logic [CNT_W:0]    occ;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready;
    // Responses to requests made before a redirect arrive in the redirect cycle; drop them.
    assign push        = inflight_q & ~redirect;
    // Slots already spoken for: buffered + in flight, minus the one leaving this cycle.
    assign occ         = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign room        = (occ < (CNT_W + 1)'(BUF_DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_valid ? mem_q[rd_ptr_q].instr : '0;
    assign instr_pc    = instr_valid ? mem_q[rd_ptr_q].pc    : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (halt) state_d = HALTED;
            HALTED:  if (redirect && !halt) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req = reset_n & (state_q == FETCH) & room & ~redirect;
        done     = (state_q == HALTED) & (count_q == '0) & ~inflight_q;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
        mem_d         = mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: imem_rdata, pc: inflight_pc_q};
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            mem_q         <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            mem_q         <= mem_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: imem model returns addr[8:0]; a stream-level model
// predicts fetch addresses and delivered PCs, plus scenario tasks for each feature.
module tb_instruction_fetch;
    localparam int PC_W = 32, INSTR_W = 9, DEPTH = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               halt = 1'b0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_ready = 1'b0;
    logic               done;

    int tests = 0;
    int fails = 0;

    instruction_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PC_STEP(4), .RESET_PC('0), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at addr is addr[8:0]; junk when not read.
    always @(posedge clk) imem_rdata <= imem_req ? imem_addr[8:0] : INSTR_W'($urandom);

    // Stream model: addresses advance by 4 per request, deliveries advance by 4 per pop,
    // both restart at the redirect target; issued-but-unpopped never exceeds DEPTH.
    bit              mon_en = 1'b0;
    logic [PC_W-1:0] exp_pc = '0, exp_addr = '0, held_pc = '0, last_pop_pc = '0;
    logic [INSTR_W-1:0] held_instr = '0;
    bit              prev_redir = 1'b0, prev_stall = 1'b0;
    int              out_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_pc = '0; exp_addr = '0; out_cnt = 0; prev_redir = 0; prev_stall = 0;
        end else if (mon_en) begin
            if (prev_redir) begin
                tests++;
                if (instr_valid !== 1'b0) begin fails++; $display("FAIL redirect_bubble valid=%b want 0", instr_valid); end
            end
            if (prev_stall) begin
                tests++;
                if (instr_valid !== 1'b1 || instr_pc !== held_pc || instr !== held_instr) begin
                    fails++; $display("FAIL stall_hold pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, held_pc, held_instr);
                end
            end
            if (instr_valid) begin
                tests++;
                if (instr !== instr_pc[8:0]) begin fails++; $display("FAIL instr_data instr=%h want %h", instr, instr_pc[8:0]); end
            end
            if (imem_req) begin
                tests++;
                if (imem_addr !== exp_addr) begin fails++; $display("FAIL fetch_addr addr=%h want %h", imem_addr, exp_addr); end
                exp_addr = exp_addr + 4;
            end
            if (instr_valid && instr_ready) begin
                tests++;
                if (instr_pc !== exp_pc) begin fails++; $display("FAIL pc_order pc=%h want %h", instr_pc, exp_pc); end
                last_pop_pc = instr_pc;
                exp_pc = exp_pc + 4;
            end
            if (redirect) begin
                exp_pc = redirect_pc; exp_addr = redirect_pc; out_cnt = 0;
            end else begin
                out_cnt = out_cnt + int'(imem_req) - int'(instr_valid && instr_ready);
                tests++;
                if (out_cnt > DEPTH) begin fails++; $display("FAIL outstanding cnt=%0d want <=%0d", out_cnt, DEPTH); end
            end
            prev_redir = redirect;
            prev_stall = instr_valid && !instr_ready && !redirect;
            held_pc = instr_pc; held_instr = instr;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({imem_req, instr_valid, done} !== 3'b000 || imem_addr !== '0 || instr !== '0 || instr_pc !== '0) begin
            fails++; $display("FAIL reset_outputs req=%b valid=%b done=%b addr=%h instr=%h pc=%h want all 0",
                              imem_req, instr_valid, done, imem_addr, instr, instr_pc);
        end
    endtask

    task automatic test_stream;
        tick; reset_n = 1'b1; mon_en = 1'b1;
        @(negedge clk); tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL stream_c0 req=%b addr=%h valid=%b want 1 0 0", imem_req, imem_addr, instr_valid);
        end
        @(negedge clk); tests++;
        if (imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
            fails++; $display("FAIL stream_c1 addr=%h valid=%b want 4 0", imem_addr, instr_valid);
        end
        @(negedge clk); tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++; $display("FAIL stream_c2 valid=%b pc=%h want 1 0", instr_valid, instr_pc);
        end
        @(negedge clk); tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            fails++; $display("FAIL stream_c3 valid=%b pc=%h want 1 4", instr_valid, instr_pc);
        end
        repeat (8) tick;
    endtask

    task automatic test_stall;
        logic [PC_W-1:0] head;
        tick; instr_ready = 1'b0;
        @(negedge clk); head = instr_pc;
        repeat (4) begin
            @(negedge clk); tests++;
            if (instr_pc !== head) begin fails++; $display("FAIL stall_head pc=%h want %h", instr_pc, head); end
        end
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
            fails++; $display("FAIL stall_full req=%b valid=%b want 0 1", imem_req, instr_valid);
        end
        tick; instr_ready = 1'b1;
        repeat (10) tick;
    endtask

    task automatic test_redirect;
        tick; instr_ready = 1'b0;
        tick;
        redirect = 1'b1; redirect_pc = 32'h100;
        tick; redirect = 1'b0; instr_ready = 1'b1;
        @(negedge clk); tests++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++; $display("FAIL redirect_n1 valid=%b req=%b addr=%h want 0 1 100", instr_valid, imem_req, imem_addr);
        end
        @(negedge clk); tests++;
        if (instr_valid !== 1'b0) begin fails++; $display("FAIL redirect_n2 valid=%b want 0", instr_valid); end
        @(negedge clk); tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            fails++; $display("FAIL redirect_n3 valid=%b pc=%h want 1 100", instr_valid, instr_pc);
        end
        @(negedge clk); tests++;
        if (instr_pc !== 32'h104) begin fails++; $display("FAIL redirect_n4 pc=%h want 104", instr_pc); end
        repeat (4) tick;
    endtask

    task automatic test_halt;
        bit hit = 0;
        tick; redirect = 1'b1; redirect_pc = 32'h0;
        tick; redirect = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h10) hit = 1;
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL halt_reach addr=%h want 10", imem_addr); end
        halt = 1'b1;
        tick; halt = 1'b0;
        @(negedge clk); tests++;
        if (imem_req !== 1'b0) begin fails++; $display("FAIL halt_stop req=%b want 0", imem_req); end
        for (int i = 0; i < 50 && !done; i++) @(negedge clk);
        tests++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || last_pop_pc !== 32'h10) begin
            fails++; $display("FAIL halt_done done=%b valid=%b last=%h want 1 0 10", done, instr_valid, last_pop_pc);
        end
        tick; redirect = 1'b1; redirect_pc = 32'h40;
        tick; redirect = 1'b0;
        @(negedge clk); tests++;
        if (done !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            fails++; $display("FAIL halt_resume done=%b req=%b addr=%h want 0 1 40", done, imem_req, imem_addr);
        end
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
            fails++; $display("FAIL halt_first valid=%b pc=%h want 1 40", instr_valid, instr_pc);
        end
        repeat (4) tick;
    endtask

    task automatic test_wrap;
        tick; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; instr_ready = 1'b1;
        tick; redirect = 1'b0;
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL wrap_first valid=%b pc=%h want 1 fffffffc", instr_valid, instr_pc);
        end
        @(negedge clk); tests++;
        if (instr_pc !== 32'h0 || instr !== 9'h0) begin
            fails++; $display("FAIL wrap_second pc=%h instr=%h want 0 0", instr_pc, instr);
        end
        repeat (4) tick;
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            tick;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0) || (done && $urandom_range(0, 1) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            halt        = ($urandom_range(0, 39) == 0);
        end
        tick; redirect = 1'b0; halt = 1'b0;
    endtask

    task automatic test_reset_mid;
        tick; redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        tick; redirect = 1'b0;
        repeat (6) tick;
        #2 reset_n = 1'b0;
        #1 tests++;
        if ({imem_req, instr_valid, done} !== 3'b000 || imem_addr !== '0 || instr_pc !== '0 || instr !== '0) begin
            fails++; $display("FAIL reset_mid req=%b valid=%b done=%b addr=%h pc=%h instr=%h want all 0",
                              imem_req, instr_valid, done, imem_addr, instr_pc, instr);
        end
        tick; reset_n = 1'b1;
        for (int i = 0; i < 50 && !instr_valid; i++) @(negedge clk);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++; $display("FAIL reset_restart valid=%b pc=%h want 1 0", instr_valid, instr_pc);
        end
        repeat (6) tick;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_halt;
        test_wrap;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
